// File: rtl/axi_write_arbiter_if.sv
// AXI3 bus bundle shared by the write arbiter and its neighbours.
// Widths derive from DATAWIDTH (ID/LEN/STRB = DATAWIDTH/8) and SIZE
// (AxSIZE = SIZE, AxBURST/xRESP = SIZE-1).
interface axi #(
  parameter int DATAWIDTH = 32,
  parameter int SIZE      = 3
);
  localparam int LW = DATAWIDTH / 8;

  // Write address channel
  logic [LW-1:0]        AWID;
  logic [DATAWIDTH-1:0] AWADDR;
  logic [LW-1:0]        AWLEN;
  logic [SIZE-1:0]      AWSIZE;
  logic [SIZE-2:0]      AWBURST;
  logic                 AWVALID;
  logic                 AWREADY;
  // Write data channel
  logic [LW-1:0]        WID;
  logic [DATAWIDTH-1:0] WDATA;
  logic [LW-1:0]        WSTRB;
  logic                 WLAST;
  logic                 WVALID;
  logic                 WREADY;
  // Write response channel
  logic [LW-1:0]        BID;
  logic [SIZE-2:0]      BRESP;
  logic                 BVALID;
  logic                 BREADY;
  // Read address channel
  logic [LW-1:0]        ARID;
  logic [DATAWIDTH-1:0] ARADDR;
  logic [LW-1:0]        ARLEN;
  logic [SIZE-1:0]      ARSIZE;
  logic [SIZE-2:0]      ARBURST;
  logic                 ARVALID;
  logic                 ARREADY;
  // Read data channel
  logic [LW-1:0]        RID;
  logic [DATAWIDTH-1:0] RDATA;
  logic [SIZE-2:0]      RRESP;
  logic                 RLAST;
  logic                 RVALID;
  logic                 RREADY;

  modport Master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input  BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport Slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/axi_write_arbiter.sv
// Two-master, one-slave AXI3 write-path arbiter.
// One whole write (AW, all W beats, B) is owned by one master at a time;
// ownership alternates round-robin under contention. WLAST toward the slave
// is regenerated from a beat counter and master WLAST disagreements are
// recorded in a sticky per-master flag. Reads from m0 pass straight through;
// m1 has no read path.
//
// Handshake rule: a transfer happens on a rising ACLK edge where VALID and
// READY are both high; only the channel belonging to the current state is
// forwarded, every other channel sees VALID/READY held low by the arbiter.
module axi_write_arbiter #(
  parameter int DATAWIDTH = 32,
  parameter int SIZE      = 3
) (
  input  logic       ACLK,
  input  logic       ARESET,
  axi.Slave          m0,
  axi.Slave          m1,
  axi.Master         s,
  output logic [1:0] grant,
  output logic [1:0] wlast_err
);
  localparam int LW = DATAWIDTH / 8;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t        state;
  logic          rr_last;    // 0 = m0 owned last, 1 = m1 owned last
  logic [LW-1:0] beat_cnt;
  logic [LW-1:0] len_q;

  logic sel;                 // 1 when m1 holds the grant
  logic in_addr, in_data, in_resp;
  logic last_beat;
  logic m_wlast;
  logic aw_hs, w_hs, b_hs;

  assign sel       = grant[1];
  assign in_addr   = (state == ADDR);
  assign in_data   = (state == DATA);
  assign in_resp   = (state == RESP);
  assign last_beat = (beat_cnt == len_q);
  assign m_wlast   = sel ? m1.WLAST : m0.WLAST;
  assign aw_hs     = s.AWVALID & s.AWREADY;
  assign w_hs      = s.WVALID & s.WREADY;
  assign b_hs      = s.BVALID & s.BREADY;

  // AW channel: owner's address forwarded only while in ADDR
  assign s.AWID    = sel ? m1.AWID    : m0.AWID;
  assign s.AWADDR  = sel ? m1.AWADDR  : m0.AWADDR;
  assign s.AWLEN   = sel ? m1.AWLEN   : m0.AWLEN;
  assign s.AWSIZE  = sel ? m1.AWSIZE  : m0.AWSIZE;
  assign s.AWBURST = sel ? m1.AWBURST : m0.AWBURST;
  assign s.AWVALID = in_addr & (sel ? m1.AWVALID : m0.AWVALID);
  assign m0.AWREADY = in_addr & grant[0] & s.AWREADY;
  assign m1.AWREADY = in_addr & grant[1] & s.AWREADY;

  // W channel: WLAST comes from the beat counter, not from the master
  assign s.WID    = sel ? m1.WID   : m0.WID;
  assign s.WDATA  = sel ? m1.WDATA : m0.WDATA;
  assign s.WSTRB  = sel ? m1.WSTRB : m0.WSTRB;
  assign s.WVALID = in_data & (sel ? m1.WVALID : m0.WVALID);
  assign s.WLAST  = in_data & last_beat;
  assign m0.WREADY = in_data & grant[0] & s.WREADY;
  assign m1.WREADY = in_data & grant[1] & s.WREADY;

  // B channel: response routed back to the owner only
  assign m0.BVALID = in_resp & grant[0] & s.BVALID;
  assign m1.BVALID = in_resp & grant[1] & s.BVALID;
  assign m0.BID    = (in_resp & grant[0]) ? s.BID   : '0;
  assign m1.BID    = (in_resp & grant[1]) ? s.BID   : '0;
  assign m0.BRESP  = (in_resp & grant[0]) ? s.BRESP : '0;
  assign m1.BRESP  = (in_resp & grant[1]) ? s.BRESP : '0;
  assign s.BREADY  = in_resp & (sel ? m1.BREADY : m0.BREADY);

  // Read path: m0 wired straight to the slave, m1 reads are never served
  assign s.ARID     = m0.ARID;
  assign s.ARADDR   = m0.ARADDR;
  assign s.ARLEN    = m0.ARLEN;
  assign s.ARSIZE   = m0.ARSIZE;
  assign s.ARBURST  = m0.ARBURST;
  assign s.ARVALID  = m0.ARVALID;
  assign m0.ARREADY = s.ARREADY;
  assign m0.RID     = s.RID;
  assign m0.RDATA   = s.RDATA;
  assign m0.RRESP   = s.RRESP;
  assign m0.RLAST   = s.RLAST;
  assign m0.RVALID  = s.RVALID;
  assign s.RREADY   = m0.RREADY;
  assign m1.ARREADY = 1'b0;
  assign m1.RID     = '0;
  assign m1.RDATA   = '0;
  assign m1.RRESP   = '0;
  assign m1.RLAST   = 1'b0;
  assign m1.RVALID  = 1'b0;

  // Transaction FSM: grant decision, burst length capture, beat counting
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state     <= IDLE;
      grant     <= 2'b00;
      rr_last   <= 1'b1;
      beat_cnt  <= '0;
      len_q     <= '0;
      wlast_err <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (m0.AWVALID && m1.AWVALID) begin
            grant <= rr_last ? 2'b01 : 2'b10;
            state <= ADDR;
          end else if (m0.AWVALID) begin
            grant <= 2'b01;
            state <= ADDR;
          end else if (m1.AWVALID) begin
            grant <= 2'b10;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (aw_hs) begin
            len_q    <= s.AWLEN;
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + LW'(1);
            if (m_wlast != last_beat) wlast_err[sel] <= 1'b1;
            if (last_beat) state <= RESP;
          end
        end
        RESP: begin
          if (b_hs) begin
            rr_last <= sel;
            grant   <= 2'b00;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter: reset, contention order, single
// bursts, blocking of a second master, WLAST checking, mid-burst reset and
// the m0 read pass-through.
module tb_axi_write_arbiter;
  logic       aclk;
  logic       areset;
  logic [1:0] grant;
  logic [1:0] wlast_err;
  int         checks;
  int         errors;

  axi #(.DATAWIDTH(32), .SIZE(3)) m0_if ();
  axi #(.DATAWIDTH(32), .SIZE(3)) m1_if ();
  axi #(.DATAWIDTH(32), .SIZE(3)) s_if ();

  axi_write_arbiter #(.DATAWIDTH(32), .SIZE(3)) dut (
    .ACLK      (aclk),
    .ARESET    (areset),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .grant     (grant),
    .wlast_err (wlast_err)
  );

  // Clock / reset
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Driver tasks
  task automatic set_aw(input int m, input logic v, input logic [31:0] a,
                        input logic [3:0] len, input logic [3:0] id);
    if (m == 0) begin
      m0_if.AWVALID = v; m0_if.AWADDR = a; m0_if.AWLEN = len; m0_if.AWID = id;
    end else begin
      m1_if.AWVALID = v; m1_if.AWADDR = a; m1_if.AWLEN = len; m1_if.AWID = id;
    end
  endtask

  task automatic set_w(input int m, input logic v, input logic [31:0] d, input logic l);
    if (m == 0) begin
      m0_if.WVALID = v; m0_if.WDATA = d; m0_if.WLAST = l;
    end else begin
      m1_if.WVALID = v; m1_if.WDATA = d; m1_if.WLAST = l;
    end
  endtask

  task automatic set_b(input int m, input logic r);
    if (m == 0) m0_if.BREADY = r;
    else        m1_if.BREADY = r;
  endtask

  // Completes a write whose owner m is currently in the address phase
  task automatic serve(input int m, input logic [3:0] len);
    tick();
    set_aw(m, 1'b0, 32'h0, 4'h0, 4'h0);
    for (int i = 0; i <= int'(len); i++) begin
      set_w(m, 1'b1, 32'hA000_0000 + i, (i == int'(len)));
      tick();
    end
    set_w(m, 1'b0, 32'h0, 1'b0);
    s_if.BVALID = 1'b1; s_if.BRESP = 2'b00;
    set_b(m, 1'b1);
    tick();
    s_if.BVALID = 1'b0;
    set_b(m, 1'b0);
  endtask

  task automatic init_signals();
    set_aw(0, 1'b0, 32'h0, 4'h0, 4'h0);
    set_aw(1, 1'b0, 32'h0, 4'h0, 4'h0);
    set_w(0, 1'b0, 32'h0, 1'b0);
    set_w(1, 1'b0, 32'h0, 1'b0);
    set_b(0, 1'b0);
    set_b(1, 1'b0);
    m0_if.AWSIZE = 3'd2; m0_if.AWBURST = 2'b01; m0_if.WID = 4'h0; m0_if.WSTRB = 4'hF;
    m1_if.AWSIZE = 3'd2; m1_if.AWBURST = 2'b01; m1_if.WID = 4'h0; m1_if.WSTRB = 4'hF;
    m0_if.ARID = 4'h0; m0_if.ARADDR = 32'h0; m0_if.ARLEN = 4'h0; m0_if.ARSIZE = 3'd2;
    m0_if.ARBURST = 2'b01; m0_if.ARVALID = 1'b0; m0_if.RREADY = 1'b0;
    m1_if.ARID = 4'h0; m1_if.ARADDR = 32'h0; m1_if.ARLEN = 4'h0; m1_if.ARSIZE = 3'd2;
    m1_if.ARBURST = 2'b01; m1_if.ARVALID = 1'b0; m1_if.RREADY = 1'b0;
    s_if.AWREADY = 1'b1; s_if.WREADY = 1'b1;
    s_if.BID = 4'h0; s_if.BRESP = 2'b00; s_if.BVALID = 1'b0;
    s_if.ARREADY = 1'b0; s_if.RID = 4'h0; s_if.RDATA = 32'h0; s_if.RRESP = 2'b00;
    s_if.RLAST = 1'b0; s_if.RVALID = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    init_signals();
    m0_if.AWVALID = 1'b1;
    #12;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++; if (wlast_err !== 2'b00) begin errors++; $display("FAIL reset_wlast_err: got %b expected 00", wlast_err); end
    checks++; if ({s_if.AWVALID, s_if.WVALID, s_if.WLAST, s_if.BREADY} !== 4'b0000) begin
      errors++; $display("FAIL reset_s_valids: got %b expected 0000", {s_if.AWVALID, s_if.WVALID, s_if.WLAST, s_if.BREADY}); end
    checks++; if ({m0_if.AWREADY, m0_if.WREADY, m0_if.BVALID, m1_if.AWREADY, m1_if.WREADY, m1_if.BVALID} !== 6'b0) begin
      errors++; $display("FAIL reset_m_readys: got %b expected 000000",
        {m0_if.AWREADY, m0_if.WREADY, m0_if.BVALID, m1_if.AWREADY, m1_if.WREADY, m1_if.BVALID}); end
    checks++; if ({m0_if.BID, m0_if.BRESP, m1_if.BID, m1_if.BRESP} !== 12'h000) begin
      errors++; $display("FAIL reset_bid_bresp: got %h expected 000", {m0_if.BID, m0_if.BRESP, m1_if.BID, m1_if.BRESP}); end
    m0_if.AWVALID = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    tick();
  endtask

  // Both masters request together from reset: m0, m1, m0, m1
  task automatic test_contention();
    set_aw(0, 1'b1, 32'h0000_0100, 4'h0, 4'h1);
    set_aw(1, 1'b1, 32'h0000_0200, 4'h0, 4'h2);
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL cont_idle_grant: got %b expected 00", grant); end
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL cont_first: got %b expected 01", grant); end
    checks++; if (s_if.AWADDR !== 32'h0000_0100 || m1_if.AWREADY !== 1'b0) begin
      errors++; $display("FAIL cont_first_aw: got addr %h m1_awready %b expected 00000100 0", s_if.AWADDR, m1_if.AWREADY); end
    serve(0, 4'h0);
    checks++; if (grant !== 2'b00 || m1_if.AWREADY !== 1'b0) begin
      errors++; $display("FAIL cont_gap: got grant %b m1_awready %b expected 00 0", grant, m1_if.AWREADY); end
    tick();
    checks++; if (grant !== 2'b10 || s_if.AWADDR !== 32'h0000_0200) begin
      errors++; $display("FAIL cont_second: got grant %b addr %h expected 10 00000200", grant, s_if.AWADDR); end
    serve(1, 4'h0);
    set_aw(0, 1'b1, 32'h0000_0300, 4'h0, 4'h1);
    set_aw(1, 1'b1, 32'h0000_0400, 4'h0, 4'h2);
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL cont_third: got %b expected 01", grant); end
    serve(0, 4'h0);
    tick();
    checks++; if (grant !== 2'b10 || s_if.AWADDR !== 32'h0000_0400) begin
      errors++; $display("FAIL cont_fourth: got grant %b addr %h expected 10 00000400", grant, s_if.AWADDR); end
    serve(1, 4'h0);
  endtask

  // m0 alone, four-beat burst with OKAY response
  task automatic test_m0_single();
    set_aw(0, 1'b1, 32'h0000_1000, 4'h3, 4'h5);
    #1;
    checks++; if (grant !== 2'b00 || s_if.AWVALID !== 1'b0) begin
      errors++; $display("FAIL single_idle: got grant %b awvalid %b expected 00 0", grant, s_if.AWVALID); end
    tick();
    checks++; if (grant !== 2'b01 || s_if.AWVALID !== 1'b1 || s_if.AWADDR !== 32'h0000_1000 || s_if.AWID !== 4'h5) begin
      errors++; $display("FAIL single_aw: got grant %b v %b addr %h id %h expected 01 1 00001000 5",
        grant, s_if.AWVALID, s_if.AWADDR, s_if.AWID); end
    checks++; if (m0_if.AWREADY !== 1'b1) begin errors++; $display("FAIL single_awready: got %b expected 1", m0_if.AWREADY); end
    tick();
    set_aw(0, 1'b0, 32'h0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      set_w(0, 1'b1, 32'hD000_0000 + i, (i == 3));
      #1;
      checks++; if (s_if.WDATA !== 32'hD000_0000 + i || s_if.WLAST !== (i == 3) || m0_if.WREADY !== 1'b1) begin
        errors++; $display("FAIL single_beat%0d: got data %h wlast %b wready %b expected %h %b 1",
          i, s_if.WDATA, s_if.WLAST, m0_if.WREADY, 32'hD000_0000 + i, (i == 3)); end
      tick();
    end
    set_w(0, 1'b0, 32'h0, 1'b0);
    s_if.BVALID = 1'b1; s_if.BRESP = 2'b00; s_if.BID = 4'h5;
    set_b(0, 1'b1);
    #1;
    checks++; if (m0_if.BVALID !== 1'b1 || m0_if.BRESP !== 2'b00 || m0_if.BID !== 4'h5 || s_if.BREADY !== 1'b1) begin
      errors++; $display("FAIL single_b: got bvalid %b bresp %b bid %h bready %b expected 1 00 5 1",
        m0_if.BVALID, m0_if.BRESP, m0_if.BID, s_if.BREADY); end
    tick();
    s_if.BVALID = 1'b0; s_if.BID = 4'h0;
    set_b(0, 1'b0);
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_after_b: got %b expected 00", grant); end
  endtask

  // m1 owns the bus; m0 request raised mid-burst must wait for B
  task automatic test_blocking();
    set_aw(1, 1'b1, 32'h0000_2000, 4'h1, 4'h6);
    tick();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL block_grant_m1: got %b expected 10", grant); end
    tick();
    set_aw(1, 1'b0, 32'h0, 4'h0, 4'h0);
    set_aw(0, 1'b1, 32'h0000_3000, 4'h0, 4'h7);
    for (int i = 0; i < 2; i++) begin
      set_w(1, 1'b1, 32'hC000_0000 + i, (i == 1));
      #1;
      checks++; if (m0_if.AWREADY !== 1'b0 || grant !== 2'b10 || s_if.WDATA !== 32'hC000_0000 + i) begin
        errors++; $display("FAIL block_beat%0d: got awready %b grant %b data %h expected 0 10 %h",
          i, m0_if.AWREADY, grant, s_if.WDATA, 32'hC000_0000 + i); end
      tick();
    end
    set_w(1, 1'b0, 32'h0, 1'b0);
    s_if.BVALID = 1'b1; s_if.BRESP = 2'b10; s_if.BID = 4'h6;
    set_b(1, 1'b1);
    #1;
    checks++; if (m0_if.AWREADY !== 1'b0 || m1_if.BVALID !== 1'b1 || m0_if.BVALID !== 1'b0 || m1_if.BRESP !== 2'b10) begin
      errors++; $display("FAIL block_resp: got m0_awready %b m1_bvalid %b m0_bvalid %b m1_bresp %b expected 0 1 0 10",
        m0_if.AWREADY, m1_if.BVALID, m0_if.BVALID, m1_if.BRESP); end
    tick();
    s_if.BVALID = 1'b0; s_if.BRESP = 2'b00; s_if.BID = 4'h0;
    set_b(1, 1'b0);
    checks++; if (grant !== 2'b00 || m0_if.AWREADY !== 1'b0) begin
      errors++; $display("FAIL block_gap: got grant %b awready %b expected 00 0", grant, m0_if.AWREADY); end
    tick();
    checks++; if (grant !== 2'b01 || s_if.AWADDR !== 32'h0000_3000) begin
      errors++; $display("FAIL block_m0_after: got grant %b addr %h expected 01 00003000", grant, s_if.AWADDR); end
    serve(0, 4'h0);
  endtask

  // m0 AWLEN=2 with WLAST on beat 2 instead of beat 3
  task automatic test_wlast_err();
    set_aw(0, 1'b1, 32'h0000_4000, 4'h2, 4'h1);
    tick();
    set_w(0, 1'b1, 32'hE000_0000, 1'b0);
    #1;
    checks++; if (m0_if.WREADY !== 1'b0 || s_if.WVALID !== 1'b0) begin
      errors++; $display("FAIL wl_early_w: got wready %b wvalid %b expected 0 0", m0_if.WREADY, s_if.WVALID); end
    tick();
    set_aw(0, 1'b0, 32'h0, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      set_w(0, 1'b1, 32'hE000_0000 + i, (i == 1));
      #1;
      checks++; if (s_if.WLAST !== (i == 2) || s_if.WVALID !== 1'b1) begin
        errors++; $display("FAIL wl_beat%0d_wlast: got wlast %b wvalid %b expected %b 1", i, s_if.WLAST, s_if.WVALID, (i == 2)); end
      checks++; if (wlast_err !== ((i == 2) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL wl_beat%0d_err: got %b expected %b", i, wlast_err, (i == 2) ? 2'b01 : 2'b00); end
      tick();
    end
    set_w(0, 1'b0, 32'h0, 1'b0);
    s_if.BVALID = 1'b1;
    set_b(0, 1'b1);
    #1;
    checks++; if (m0_if.BVALID !== 1'b1) begin errors++; $display("FAIL wl_resp: got bvalid %b expected 1", m0_if.BVALID); end
    tick();
    s_if.BVALID = 1'b0;
    set_b(0, 1'b0);
    checks++; if (wlast_err !== 2'b01 || grant !== 2'b00) begin
      errors++; $display("FAIL wl_sticky: got err %b grant %b expected 01 00", wlast_err, grant); end
  endtask

  // Reset pulsed in the middle of a four-beat burst
  task automatic test_mid_reset();
    set_aw(0, 1'b1, 32'h0000_5000, 4'h3, 4'h2);
    tick();
    tick();
    set_aw(0, 1'b0, 32'h0, 4'h0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      set_w(0, 1'b1, 32'hF000_0000 + i, 1'b0);
      tick();
    end
    set_w(0, 1'b1, 32'hF000_0002, 1'b0);
    #1;
    checks++; if (s_if.WVALID !== 1'b1) begin errors++; $display("FAIL mr_before: got wvalid %b expected 1", s_if.WVALID); end
    areset = 1'b1;
    #1;
    checks++; if (s_if.WVALID !== 1'b0 || grant !== 2'b00 || wlast_err !== 2'b00) begin
      errors++; $display("FAIL mr_async: got wvalid %b grant %b err %b expected 0 00 00", s_if.WVALID, grant, wlast_err); end
    set_w(0, 1'b0, 32'h0, 1'b0);
    #1;
    areset = 1'b0;
    tick();
    set_aw(0, 1'b1, 32'h0000_6000, 4'h0, 4'h3);
    tick();
    checks++; if (grant !== 2'b01 || s_if.AWADDR !== 32'h0000_6000 || s_if.AWVALID !== 1'b1) begin
      errors++; $display("FAIL mr_regrant: got grant %b addr %h v %b expected 01 00006000 1", grant, s_if.AWADDR, s_if.AWVALID); end
    serve(0, 4'h0);
  endtask

  // m0 four-beat read while m1 performs a two-beat write
  task automatic test_read_concurrent();
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: begin
          set_aw(1, 1'b1, 32'h0000_7000, 4'h1, 4'h3);
          m0_if.ARVALID = 1'b1; m0_if.ARADDR = 32'h0000_8000; m0_if.ARLEN = 4'h3;
          m1_if.ARVALID = 1'b1; m1_if.ARADDR = 32'h0000_9000;
          s_if.ARREADY = 1'b1;
        end
        1: m0_if.ARVALID = 1'b0;
        2: begin set_aw(1, 1'b0, 32'h0, 4'h0, 4'h0); set_w(1, 1'b1, 32'h1111_0000, 1'b0); end
        3: set_w(1, 1'b1, 32'h1111_0001, 1'b1);
        default: begin set_w(1, 1'b0, 32'h0, 1'b0); s_if.BVALID = 1'b1; set_b(1, 1'b1); end
      endcase
      if (c > 0) begin
        s_if.RVALID = 1'b1; s_if.RDATA = 32'hBEEF_0000 + (c - 1); s_if.RLAST = (c == 4);
        s_if.RID = 4'h2; m0_if.RREADY = 1'b1;
      end
      #1;
      if (c == 0) begin
        checks++; if (s_if.ARVALID !== 1'b1 || s_if.ARADDR !== 32'h0000_8000 || m0_if.ARREADY !== 1'b1) begin
          errors++; $display("FAIL rd_ar: got v %b addr %h ready %b expected 1 00008000 1", s_if.ARVALID, s_if.ARADDR, m0_if.ARREADY); end
      end else begin
        checks++; if (m0_if.RDATA !== 32'hBEEF_0000 + (c - 1) || m0_if.RVALID !== 1'b1 || m0_if.RLAST !== (c == 4) ||
                      m0_if.RID !== 4'h2 || s_if.RREADY !== 1'b1) begin
          errors++; $display("FAIL rd_beat%0d: got data %h v %b last %b id %h rready %b expected %h 1 %b 2 1",
            c - 1, m0_if.RDATA, m0_if.RVALID, m0_if.RLAST, m0_if.RID, s_if.RREADY, 32'hBEEF_0000 + (c - 1), (c == 4)); end
      end
      checks++; if (m1_if.ARREADY !== 1'b0 || m1_if.RVALID !== 1'b0 || m1_if.RDATA !== 32'h0) begin
        errors++; $display("FAIL rd_m1_c%0d: got arready %b rvalid %b rdata %h expected 0 0 0",
          c, m1_if.ARREADY, m1_if.RVALID, m1_if.RDATA); end
      if (c == 1) begin
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rd_wr_grant: got %b expected 10", grant); end
      end
      if (c == 3) begin
        checks++; if (s_if.WLAST !== 1'b1 || s_if.WDATA !== 32'h1111_0001) begin
          errors++; $display("FAIL rd_wr_last: got wlast %b data %h expected 1 11110001", s_if.WLAST, s_if.WDATA); end
      end
      if (c == 4) begin
        checks++; if (m1_if.BVALID !== 1'b1) begin errors++; $display("FAIL rd_wr_b: got %b expected 1", m1_if.BVALID); end
      end
      tick();
    end
    s_if.BVALID = 1'b0; set_b(1, 1'b0);
    s_if.RVALID = 1'b0; s_if.RLAST = 1'b0; s_if.ARREADY = 1'b0;
    m0_if.RREADY = 1'b0; m1_if.ARVALID = 1'b0;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rd_end_grant: got %b expected 00", grant); end
  endtask

  // Test sequence and final report
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_contention();
    test_m0_single();
    test_blocking();
    test_wlast_err();
    test_mid_reset();
    test_read_concurrent();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
